// File: rtl/network_stream_feeder.sv
// network_stream_feeder
// Replays a buffer of up to DEPTH samples into a valid/ready stream for on-chip self-test.
// Samples are loaded through a write port while IDLE; a start pulse replays them in write
// order. An optional LFSR throttle inserts idle cycles between beats.
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   wr_en, wr_data   append a sample to the buffer (IDLE only)
//   clear            empty the buffer (IDLE only)
//   start            begin replay (IDLE only)
//   throttle_en      gate new beats with LFSR bit 0
//   m_ready          downstream accepts the current beat
//   m_valid,data_out beat being offered downstream
//   wr_full          buffer holds DEPTH samples
//   loaded_count     number of samples held
//   busy             replay in progress
//   done             one-cycle pulse after the last beat is accepted
module network_stream_feeder #(
  parameter int unsigned T     = 8,
  parameter int unsigned DEPTH = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [T-1:0]                 wr_data,
  input  logic                         clear,
  input  logic                         start,
  input  logic                         throttle_en,
  input  logic                         m_ready,
  output logic                         m_valid,
  output logic [T-1:0]                 data_out,
  output logic                         wr_full,
  output logic [$clog2(DEPTH+1)-1:0]   loaded_count,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            valid_q, valid_d;
  logic [T-1:0]    data_q, data_d;
  logic            done_q, done_d;
  logic [15:0]     lfsr_q;
  logic            wr_we;
  logic [T-1:0]    sample_mem [DEPTH];

  logic            full;
  logic            gate;
  logic            hs;
  logic            last;
  logic [PW-1:0]   rd_next;

  assign full    = (cnt_q == CW'(DEPTH));
  assign gate    = !throttle_en || lfsr_q[0];
  assign hs      = valid_q && m_ready;
  assign last    = (CW'(rd_ptr_q) == (cnt_q - CW'(1)));
  assign rd_next = rd_ptr_q + PW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    data_d   = data_q;
    done_d   = 1'b0;
    wr_we    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          rd_ptr_d = '0;
          state_d  = (cnt_q != '0) ? StRun : StDone;
          done_d   = (cnt_q == '0);
        end else if (clear) begin
          cnt_d = '0;
        end else if (wr_en && !full) begin
          wr_we = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      StRun: begin
        if (hs) begin
          if (last) begin
            valid_d = 1'b0;
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            rd_ptr_d = rd_next;
            // Load the next beat on the same edge for back-to-back streaming
            valid_d  = gate;
            if (gate) data_d = sample_mem[rd_next];
          end
        end else if (!valid_q && gate) begin
          valid_d = 1'b1;
          data_d  = sample_mem[rd_ptr_q];
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      lfsr_q   <= SEED;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      done_q   <= done_d;
      // Fibonacci taps 16,14,13,11
      lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // Buffer contents need no reset; loaded_count defines which entries are valid
  always_ff @(posedge clk) begin
    if (wr_we) sample_mem[cnt_q[PW-1:0]] <= wr_data;
  end

  assign m_valid      = valid_q;
  assign data_out     = data_q;
  assign wr_full      = full;
  assign loaded_count = cnt_q;
  assign busy         = (state_q == StRun);
  assign done         = done_q;

endmodule

// File: tb/tb_network_stream_feeder.sv
module tb_network_stream_feeder;

  localparam int T     = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [T-1:0]  wr_data = '0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          throttle_en = 1'b0;
  logic          m_ready = 1'b0;
  logic          m_valid;
  logic [T-1:0]  data_out;
  logic          wr_full;
  logic [CW-1:0] loaded_count;
  logic          busy;
  logic          done;

  network_stream_feeder #(.T(T), .DEPTH(DEPTH), .SEED(16'hACE1)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clear        (clear),
    .start        (start),
    .throttle_en  (throttle_en),
    .m_ready      (m_ready),
    .m_valid      (m_valid),
    .data_out     (data_out),
    .wr_full      (wr_full),
    .loaded_count (loaded_count),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the ordered list of samples the buffer should hold
  logic [T-1:0] model_q[$];

  // Results of the latest replay
  int r_beats, r_dones, r_first, r_done_at, r_valid_cyc, r_stall, r_vis, r_held, r_extra;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge
  task automatic write(input logic [T-1:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(d);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_q.delete();
  endtask

  // Start a replay and watch the stream until a few cycles past done (bounded)
  task automatic replay(input bit thr, input int ready_pct, input int hold_beat,
                        input int hold_len);
    logic [T-1:0] exp_q[$];
    logic [T-1:0] pend_data;
    bit           pend;
    int           post;
    exp_q = model_q;
    r_beats = 0; r_dones = 0; r_first = -1; r_done_at = -1; r_valid_cyc = 0;
    r_stall = 0; r_vis = 0; r_held = 0; r_extra = 0;
    pend = 1'b0; pend_data = '0; post = 0;
    throttle_en = thr;
    m_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 3000 && post < 4; c++) begin
      if (m_valid && r_beats == hold_beat && r_held < hold_len) begin
        m_ready = 1'b0;
        r_held++;
      end else begin
        m_ready = ($urandom_range(99) < ready_pct);
      end
      if (m_valid && !busy) r_vis++;
      if (pend && !(m_valid && data_out == pend_data)) r_stall++;
      if (m_valid) r_valid_cyc++;
      if (m_valid && r_first < 0) r_first = c;
      if (done) begin
        r_dones++;
        r_done_at = c;
      end
      if (r_dones > 0) post++;
      if (m_valid && m_ready) begin
        r_beats++;
        if (exp_q.size() == 0) r_extra++;
        else chk("beat_data", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
        pend = 1'b0;
      end else begin
        pend = m_valid;
        pend_data = data_out;
      end
      @(negedge clk);
    end
    m_ready = 1'b0;
    throttle_en = 1'b0;
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_beats"}, r_beats, model_q.size());
    chk({tag, "_dones"}, r_dones, 1);
    chk({tag, "_stall"}, r_stall, 0);
    chk({tag, "_outside_run"}, r_vis, 0);
    chk({tag, "_extra"}, r_extra, 0);
  endtask

  initial begin
    int acc;
    int ndone;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_count", loaded_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_full", wr_full, 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: four samples, free-flowing: valid on four consecutive cycles then done
    write(8'h01); write(8'h7F); write(8'h80); write(8'hFF);
    chk("t1_count", loaded_count, 4);
    replay(1'b0, 100, -1, 0);
    check_run("t1");
    chk("t1_first_valid", r_first, 2);
    chk("t1_valid_cycles", r_valid_cyc, 4);
    chk("t1_done_at", r_done_at, 6);
    chk("t1_count_kept", loaded_count, 4);

    // 2: same buffer, second beat stalled three cycles
    replay(1'b0, 100, 1, 3);
    check_run("t2");
    chk("t2_held", r_held, 3);

    // clear beats a simultaneous write
    clear = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h55;
    @(negedge clk);
    clear = 1'b0;
    wr_en = 1'b0;
    model_q.delete();
    chk("clear_prio_count", loaded_count, 0);

    // 3: fill to DEPTH, overflow write dropped
    for (int i = 0; i < DEPTH; i++) write(T'(i));
    chk("t3_full", wr_full, 1);
    chk("t3_count", loaded_count, DEPTH);
    write(8'hAA);
    chk("t3_count_after_ovf", loaded_count, DEPTH);
    chk("t3_full_after_ovf", wr_full, 1);
    replay(1'b0, 100, -1, 0);
    check_run("t3");

    // 4: throttled with random backpressure, replayed twice
    replay(1'b1, 50, -1, 0);
    check_run("t4a");
    replay(1'b1, 50, -1, 0);
    check_run("t4b");

    // 5: empty buffer skips RUN
    do_clear();
    chk("t5_count", loaded_count, 0);
    replay(1'b0, 100, -1, 0);
    check_run("t5");
    chk("t5_first_valid", r_first, -1);
    chk("t5_done_at", r_done_at, 1);

    // 6: reset mid-replay after two beats
    for (int i = 0; i < 4; i++) write(T'($urandom));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 40 && acc < 2; c++) begin
      if (m_valid && m_ready) acc++;
      @(negedge clk);
    end
    chk("t6_two_beats", acc, 2);
    reset = 1'b0;
    #1;
    chk("t6_async_valid", m_valid, 0);
    chk("t6_count", loaded_count, 0);
    chk("t6_busy", busy, 0);
    model_q.delete();
    m_ready = 1'b0;
    ndone = 0;
    @(negedge clk);
    if (done) ndone++;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t6_no_done", ndone, 0);
    for (int i = 0; i < 3; i++) write(T'($urandom));
    chk("t6_reload_count", loaded_count, 3);
    replay(1'b1, 70, -1, 0);
    check_run("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
